axis_result_tx: RTL and testbench

Output-side AXI-Stream transmitter for the convolution engine. It accepts results from the conv MAC, which has a valid strobe but no ready, and buffers them in a FIFO. It drives the master AXI-Stream toward the DMA with full tready backpressure, generates tlast at the end of each feature-map frame, and flags any result lost to overflow.

---
 rtl/cnn_pkg.sv | 15 +
 rtl/sync_fifo.sv | 58 +++++
 rtl/axis_result_tx.sv | 106 ++++++++++
 tb/tb_axis_result_tx.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types and geometry helpers for the convolution engine.
// Frame length is derived from image and kernel size.
package cnn_pkg;

  localparam int OUT_WIDTH = 32;
  localparam int IMG_WIDTH = 28;
  localparam int KERNEL    = 3;

  typedef logic signed [OUT_WIDTH-1:0] result_t;

  function automatic int frame_len(input int img, input int k);
    return (img - k + 1) * (img - k + 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head.
// Caller must not push when full without a pop, nor pop when empty.
module sync_fifo #(
  parameter int W  = 32,
  parameter int D  = 16,
  parameter int LW = $clog2(D) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o
);

  localparam int AW = $clog2(D);

  logic [W-1:0]  mem_q [D];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [LW-1:0] lvl_q, lvl_d;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    lvl_d = lvl_q;
    if (push_i) wr_d = wr_q + AW'(1);
    if (pop_i)  rd_d = rd_q + AW'(1);
    if (push_i && !pop_i) lvl_d = lvl_q + LW'(1);
    if (pop_i && !push_i) lvl_d = lvl_q - LW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
    end
  end

  // Storage needs no reset: pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_q];
  assign full_o  = (lvl_q == LW'(D));
  assign empty_o = (lvl_q == '0);
  assign level_o = lvl_q;

endmodule

// File: rtl/axis_result_tx.sv
// AXI-Stream transmitter for conv results: buffers a stall-free
// strobe, frames beats with tlast and flags dropped words.
module axis_result_tx #(
  parameter int OUT_WIDTH  = cnn_pkg::OUT_WIDTH,
  parameter int IMG_WIDTH  = cnn_pkg::IMG_WIDTH,
  parameter int KERNEL     = cnn_pkg::KERNEL,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_valid,
  input  logic [OUT_WIDTH-1:0]          i_data,
  input  logic                          i_clear_ovf,
  output logic [OUT_WIDTH-1:0]          m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic                          o_overflow,
  output logic                          o_frame_done,
  output logic [$clog2(FIFO_DEPTH):0]   o_level
);

  import cnn_pkg::*;

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int FL = frame_len(IMG_WIDTH, KERNEL);
  localparam int CW = (FL > 1) ? $clog2(FL) : 1;

  logic                 full, empty, pop, push, drop, hs, at_end;
  logic [OUT_WIDTH-1:0] head;
  logic [LW-1:0]        level;

  logic                 tvalid_q, tvalid_d;
  logic                 tlast_q, tlast_d;
  logic [OUT_WIDTH-1:0] tdata_q, tdata_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 done_q, done_d;

  assign hs     = tvalid_q && m_axis_tready;
  assign pop    = !empty && (!tvalid_q || m_axis_tready);
  assign push   = i_valid && (!full || pop);
  assign drop   = i_valid && full && !pop;
  assign at_end = (cnt_q == CW'(FL - 1));

  sync_fifo #(
    .W  (OUT_WIDTH),
    .D  (FIFO_DEPTH),
    .LW (LW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (i_data),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  // Counter tracks loads so framing follows what was actually sent.
  always_comb begin
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    tdata_d  = tdata_q;
    cnt_d    = cnt_q;
    if (pop) begin
      tdata_d  = head;
      tvalid_d = 1'b1;
      tlast_d  = at_end;
      cnt_d    = at_end ? '0 : cnt_q + CW'(1);
    end else if (hs) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end
    ovf_d  = drop ? 1'b1 : (i_clear_ovf ? 1'b0 : ovf_q);
    done_d = hs && tlast_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tdata_q  <= tdata_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign o_overflow    = ovf_q;
  assign o_frame_done  = done_q;
  assign o_level       = level;

endmodule

// File: tb/tb_axis_result_tx.sv
// Directed bench for axis_result_tx with a 16-beat frame
// (6x6 image, 3x3 kernel) and a 16-deep buffer.
module tb_axis_result_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic [31:0] i_data;
  logic        i_clear_ovf;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        o_overflow;
  logic        o_frame_done;
  logic [4:0]  o_level;

  int errors = 0;
  int checks = 0;

  axis_result_tx #(
    .OUT_WIDTH  (32),
    .IMG_WIDTH  (6),
    .KERNEL     (3),
    .FIFO_DEPTH (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_valid       (i_valid),
    .i_data        (i_data),
    .i_clear_ovf   (i_clear_ovf),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .o_overflow    (o_overflow),
    .o_frame_done  (o_frame_done),
    .o_level       (o_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    i_valid     = 1'b0;
    i_data      = '0;
    i_clear_ovf = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_tvalid"}, m_axis_tvalid, 0);
    chk({tag, "_tdata"}, m_axis_tdata, 0);
    chk({tag, "_tlast"}, m_axis_tlast, 0);
    chk({tag, "_ovf"}, o_overflow, 0);
    chk({tag, "_done"}, o_frame_done, 0);
    chk({tag, "_level"}, o_level, 0);
  endtask

  initial begin
    int b;
    int nd;
    logic prev_last;

    // 1: reset state and single result
    m_axis_tready = 1'b1;
    rst_n = 1'b0;
    i_valid = 1'b0;
    i_data = '0;
    i_clear_ovf = 1'b0;
    #2;
    chk_zero("rst");
    do_reset();
    i_valid = 1'b1;
    i_data  = 32'h0000_002A;
    step();
    i_valid = 1'b0;
    chk("single_e1_tvalid", m_axis_tvalid, 0);
    chk("single_e1_level", o_level, 1);
    step();
    chk("single_tvalid", m_axis_tvalid, 1);
    chk("single_tdata", m_axis_tdata, 32'h2A);
    chk("single_tlast", m_axis_tlast, 0);
    chk("single_level", o_level, 0);
    step();
    chk("single_after_tvalid", m_axis_tvalid, 0);

    // 2: backpressure hold
    do_reset();
    m_axis_tready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      i_valid = 1'b1;
      i_data  = i;
      step();
    end
    i_valid = 1'b0;
    chk("bp_tvalid", m_axis_tvalid, 1);
    chk("bp_tdata", m_axis_tdata, 1);
    chk("bp_level", o_level, 4);
    step();
    step();
    chk("bp_hold_tvalid", m_axis_tvalid, 1);
    chk("bp_hold_tdata", m_axis_tdata, 1);
    m_axis_tready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("bp_beat%0d_tvalid", k), m_axis_tvalid, 1);
      chk($sformatf("bp_beat%0d_tdata", k), m_axis_tdata, k);
      step();
    end
    chk("bp_drained_tvalid", m_axis_tvalid, 0);
    chk("bp_drained_level", o_level, 0);

    // 3: two full frames back to back
    do_reset();
    m_axis_tready = 1'b1;
    b = 0;
    nd = 0;
    prev_last = 1'b0;
    for (int c = 0; c < 40; c++) begin
      chk($sformatf("frm_c%0d_done", c), o_frame_done, prev_last);
      if (o_frame_done) nd++;
      prev_last = m_axis_tvalid && m_axis_tlast;
      if (m_axis_tvalid) begin
        chk($sformatf("frm_b%0d_tdata", b), m_axis_tdata, 100 + b);
        chk($sformatf("frm_b%0d_tlast", b), m_axis_tlast,
            (b == 15) || (b == 31));
        b++;
      end
      i_valid = (c < 32);
      i_data  = 100 + c;
      step();
    end
    i_valid = 1'b0;
    chk("frm_beats", b, 32);
    chk("frm_done_count", nd, 2);

    // 4: overflow, sticky flag, clear
    do_reset();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      i_valid = 1'b1;
      i_data  = 200 + i;
      step();
    end
    chk("ovf_pre_flag", o_overflow, 0);
    chk("ovf_pre_level", o_level, 16);
    i_data = 217;
    step();
    i_valid = 1'b0;
    chk("ovf_flag", o_overflow, 1);
    chk("ovf_level", o_level, 16);
    chk("ovf_tdata", m_axis_tdata, 200);
    step();
    step();
    chk("ovf_sticky", o_overflow, 1);
    i_clear_ovf = 1'b1;
    step();
    i_clear_ovf = 1'b0;
    chk("ovf_cleared", o_overflow, 0);

    // 5: full FIFO with simultaneous push and pop
    m_axis_tready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      chk($sformatf("fp_n%0d_level", n), o_level, 16);
      chk($sformatf("fp_n%0d_ovf", n), o_overflow, 0);
      chk($sformatf("fp_n%0d_tdata", n), m_axis_tdata,
          (n < 17) ? 200 + n : 300 + (n - 17));
      chk($sformatf("fp_n%0d_tlast", n), m_axis_tlast, n == 15);
      i_valid = 1'b1;
      i_data  = 300 + n;
      step();
    end
    i_valid = 1'b0;
    chk("fp_final_ovf", o_overflow, 0);

    // 6: async reset mid-frame
    do_reset();
    m_axis_tready = 1'b1;
    b = 0;
    for (int c = 0; c < 30; c++) begin
      if (m_axis_tvalid) b++;
      i_valid = 1'b1;
      i_data  = 400 + c;
      step();
      if (b == 7) break;
    end
    chk("ar_beats_before", b, 7);
    chk("ar_level_nonzero", o_level != 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("ar_async");
    i_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    chk("ar_post_tvalid", m_axis_tvalid, 0);
    b = 0;
    for (int c = 0; c < 24; c++) begin
      if (m_axis_tvalid) begin
        chk($sformatf("ar_b%0d_tdata", b), m_axis_tdata, 500 + b);
        chk($sformatf("ar_b%0d_tlast", b), m_axis_tlast, b == 15);
        b++;
      end
      i_valid = (c < 20);
      i_data  = 500 + c;
      step();
    end
    i_valid = 1'b0;
    chk("ar_beats_after", b, 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
